// File: rtl/bus_transfer_controller_pkg.sv
// Shared types and constants for the internal-bus transfer sequencer and the
// tri-state buffers it enables.
package bus_transfer_controller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StLoad,
    StTurn
  } state_e;

  localparam int unsigned BusDataWidth = 8;

  // Bits needed to index num_dst destinations; never narrower than one bit.
  function automatic int unsigned dst_idx_width(int unsigned num_dst);
    return (num_dst > 1) ? $clog2(num_dst) : 1;
  endfunction

endpackage

// File: rtl/bus_transfer_controller_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping to the lowest set request below it.
module bus_transfer_controller_rr_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IdxW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic               grant_valid_o,
  output logic [IdxW-1:0]    grant_idx_o
);

  logic            found_hi;
  logic [IdxW-1:0] idx_hi;
  logic            found_lo;
  logic [IdxW-1:0] idx_lo;

  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!found_hi && req_i[i] && (i >= 32'(ptr_i))) begin
        found_hi = 1'b1;
        idx_hi   = IdxW'(i);
      end
    end
  end

  // Wrap-around pass: only consulted when nothing at or above the pointer asks.
  always_comb begin
    found_lo = 1'b0;
    idx_lo   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!found_lo && req_i[i]) begin
        found_lo = 1'b1;
        idx_lo   = IdxW'(i);
      end
    end
  end

  always_comb begin
    grant_valid_o = found_hi | found_lo;
    grant_idx_o   = found_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/bus_transfer_controller.sv
// Sequencer for the shared internal data bus: round-robin grant, drive, load,
// then a high-Z turnaround cycle before the next owner.
module bus_transfer_controller
  import bus_transfer_controller_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned NUM_DST    = 4,
  parameter int unsigned DATA_WIDTH = BusDataWidth,
  parameter int unsigned DST_W      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       req_i,
  input  logic [NUM_SRC*DST_W-1:0] req_dst_i,
  input  logic [DATA_WIDTH-1:0]    bus_data_i,
  output logic [NUM_SRC-1:0]       drive_en_o,
  output logic [NUM_DST-1:0]       load_en_o,
  output logic [NUM_SRC-1:0]       ack_o,
  output logic                     busy_o,
  output logic [DATA_WIDTH-1:0]    captured_data_o,
  output logic                     dst_err_o
);

  localparam int unsigned SrcW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned DstMinW = dst_idx_width(NUM_DST);
  // Wide enough to hold both any dst field and the value NUM_DST itself.
  localparam int unsigned CmpW    = ((DST_W > DstMinW) ? DST_W : DstMinW) + 1;

  state_e state_q, state_d;
  logic [SrcW-1:0]  grant_q, grant_d;
  logic [DST_W-1:0] dst_q, dst_d;
  logic [SrcW-1:0]  ptr_q, ptr_d;

  logic [NUM_SRC-1:0]    drive_en_q, drive_en_d;
  logic [NUM_DST-1:0]    load_en_q, load_en_d;
  logic [NUM_SRC-1:0]    ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  dst_err_q, dst_err_d;
  logic [DATA_WIDTH-1:0] captured_data_q, captured_data_d;

  logic             arb_valid;
  logic [SrcW-1:0]  arb_idx;
  logic [DST_W-1:0] arb_dst;
  logic             dst_q_valid;
  logic             dst_d_valid;

  bus_transfer_controller_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IdxW    (SrcW)
  ) u_rr_arbiter (
    .req_i         (req_i),
    .ptr_i         (ptr_q),
    .grant_valid_o (arb_valid),
    .grant_idx_o   (arb_idx)
  );

  always_comb begin
    arb_dst = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (arb_idx == SrcW'(i)) begin
        arb_dst = req_dst_i[i*DST_W +: DST_W];
      end
    end
  end

  assign dst_q_valid = CmpW'(dst_q) < CmpW'(NUM_DST);
  assign dst_d_valid = CmpW'(dst_d) < CmpW'(NUM_DST);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      dst_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dst_q   <= dst_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic; grant index and destination are frozen at grant time.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    dst_d   = dst_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d = StDrive;
          grant_d = arb_idx;
          dst_d   = arb_dst;
        end
      end
      StDrive: state_d = StLoad;
      StLoad: begin
        state_d = StTurn;
        ptr_d   = (grant_q == SrcW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered
  // without adding a cycle of latency; no comb path from req_i to drive_en_o.
  always_comb begin
    drive_en_d      = '0;
    load_en_d       = '0;
    ack_d           = '0;
    busy_d          = (state_d != StIdle);
    dst_err_d       = (state_d == StLoad) && !dst_d_valid;
    captured_data_d = captured_data_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      drive_en_d[i] = (state_d inside {StDrive, StLoad}) && (grant_d == SrcW'(i));
      ack_d[i]      = (state_d == StLoad) && (grant_d == SrcW'(i));
    end
    for (int unsigned i = 0; i < NUM_DST; i++) begin
      load_en_d[i] = (state_d == StLoad) && dst_d_valid && (dst_d == DST_W'(i));
    end
    if ((state_q == StLoad) && dst_q_valid) begin
      captured_data_d = bus_data_i;
    end
  end

  // Async clear drops the buffer enables immediately, abandoning any transfer.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      drive_en_q      <= '0;
      load_en_q       <= '0;
      ack_q           <= '0;
      busy_q          <= 1'b0;
      dst_err_q       <= 1'b0;
      captured_data_q <= '0;
    end else begin
      drive_en_q      <= drive_en_d;
      load_en_q       <= load_en_d;
      ack_q           <= ack_d;
      busy_q          <= busy_d;
      dst_err_q       <= dst_err_d;
      captured_data_q <= captured_data_d;
    end
  end

  assign drive_en_o      = drive_en_q;
  assign load_en_o       = load_en_q;
  assign ack_o           = ack_q;
  assign busy_o          = busy_q;
  assign dst_err_o       = dst_err_q;
  assign captured_data_o = captured_data_q;

endmodule

// File: doc/bus_transfer_controller.md
Name: bus_transfer_controller

Overview:
- Sequencer for the CPU's shared 8-bit internal data bus. The bus is driven by per-source tri-state buffers.
- Arbitrates between source requests with a round-robin policy. Drives exactly one source's buffer enable, then strobes the requested destination's load enable.
- Inserts a turnaround cycle (bus high-Z) between owners so two buffers never drive the bus at once.
- Sits directly upstream of the tri-state buffers (its drive_en bits are their enable inputs) and reads the resolved bus value back.

Parameters:
- NUM_SRC, 4, number of bus sources (tri-state buffers), 2..8.
- NUM_DST, 4, number of destination registers, 1..16.
- DATA_WIDTH, 8, bus width.
- DST_W, 4, width of each destination index field (must satisfy 2**DST_W >= NUM_DST).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_SRC  per-source transfer request; held high until matching ack.
- req_dst  in  NUM_SRC*DST_W  packed destination index per source; field i = bits [i*DST_W +: DST_W].
- bus_data  in  DATA_WIDTH  resolved value of the shared bus.
- drive_en  out  NUM_SRC  one-hot/zero enables to the source tri-state buffers.
- load_en  out  NUM_DST  one-hot/zero load strobe to destination registers.
- ack  out  NUM_SRC  one-cycle completion pulse to the granted source.
- busy  out  1  high whenever state != IDLE.
- captured_data  out  DATA_WIDTH  bus value latched on the last completed transfer.
- dst_err  out  1  one-cycle pulse when the granted req_dst >= NUM_DST.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - state = IDLE; all outputs 0; RR pointer = 0; captured_data = 0.
  - drive_en must drop in the same instant, with no wait for a clock edge.
- All outputs are registered; no combinational path from req to drive_en.
- States: IDLE, DRIVE, LOAD, TURN.
- IDLE:
  - If any req bit is high, pick the first set bit scanning upward from the RR pointer, with wrap-around. Latch grant index g and dst = req_dst field g, then go to DRIVE.
  - If no req bit is high, stay in IDLE.
- DRIVE (1 cycle): drive_en[g]=1 so the bus settles. load_en=0. Go to LOAD.
- LOAD (1 cycle):
  - drive_en[g]=1 and ack[g]=1.
  - If dst < NUM_DST: load_en[dst]=1 and captured_data <= bus_data at the end of the cycle.
  - If dst >= NUM_DST: load_en stays 0, dst_err=1, captured_data is unchanged.
  - RR pointer <= (g+1) mod NUM_SRC. Go to TURN.
- TURN (1 cycle): drive_en=0, load_en=0. Go to IDLE unconditionally.
- Throughput and latency:
  - One transfer takes 4 cycles including IDLE arbitration.
  - First drive_en rises 1 cycle after req is sampled high.
  - Back-to-back transfers from different sources always have at least one all-zero drive_en cycle between them.
- Handshake:
  - g and dst are frozen at grant.
  - If req[g] drops mid-transfer, the transfer still completes and ack still pulses.
  - A source that holds req after its ack is treated as a new request.
  - Changes to req_dst after grant are ignored.
- Invariant: popcount(drive_en) <= 1 and popcount(load_en) <= 1 every cycle. load_en is high only while drive_en is high.
- Simultaneous requests resolve by the RR pointer only. No source wins twice in a row while another source is requesting.
- When rst_n asserts mid-transfer, the transfer is abandoned: no ack and no load. After release, arbitration restarts with pointer 0.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DRIVE, LOAD, TURN);
  - the DATA_WIDTH default of 8, shared with the tri-state buffer;
  - a helper function computing the destination index width.
- One sub-module: rr_arbiter, which is combinational. Inputs are req and the pointer; outputs are grant_valid and grant_idx. It is instantiated once.
- The FSM, latches and pointer update stay in the top module.

Test Plan:
- Single request:
  - Stimulus: req=0001, req_dst[0]=2, bus_data=8'hA5 while drive_en[0] is high.
  - Required: drive_en=0001 on cycles 1-2; load_en=0100 and ack=0001 on cycle 2; captured_data=8'hA5 from cycle 3; cycle 3 all enables 0; busy high on cycles 1-3.
- Round-robin:
  - Stimulus: req=1111 held constant.
  - Required: grants in order 0,1,2,3,0; each transfer spans 4 cycles; every TURN cycle has drive_en=0000; the invariant holds throughout.
- Pointer wrap:
  - Stimulus: after a grant to source 3, assert req=1001.
  - Required: source 0 is granted before source 3.
- Invalid destination:
  - Stimulus: NUM_DST=3, req_dst=3.
  - Required: ack pulses, dst_err=1 for exactly one cycle, load_en stays 000, captured_data is unchanged.
- Request withdrawn:
  - Stimulus: req[1] drops during DRIVE.
  - Required: LOAD and ack[1] still occur; the FSM returns to IDLE with no new grant.
- Reset mid-transfer:
  - Stimulus: rst_n low in the middle of the LOAD cycle.
  - Required: drive_en and load_en go to 0 before the next clk edge; no ack; after release with req=0010, the grant goes to source 1 after a 1-cycle latency.
